// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery helpers: FSM state encoding and
// width helpers used by both from_montgomery and the R^2 generation logic.
package mont_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ITER    = 2'd1,
    CORRECT = 2'd2
  } mont_state_e;

  // Accumulator holds T + m*N before each halving, so one bit above 2*DATA_WIDTH.
  function automatic int acc_width(input int data_width);
    return 2 * data_width + 1;
  endfunction

  function automatic int cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/mont_cond_sub.sv
// Final Montgomery correction: reduces an accumulator known to be < 2N
// into [0, N) with a single conditional subtraction.
module mont_cond_sub
  import mont_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [2*DATA_WIDTH:0]  acc,
  input  logic [DATA_WIDTH-1:0]  modulant,
  output logic [DATA_WIDTH-1:0]  reduced
);

  localparam int ACC_W = acc_width(DATA_WIDTH);

  logic [ACC_W-1:0] n_ext;
  logic             ge_n;

  always_comb begin
    n_ext = {{(ACC_W-DATA_WIDTH){1'b0}}, modulant};
    ge_n  = (acc >= n_ext);
    // When acc >= N the true difference is < N, so the low bits alone are exact.
    if (ge_n) begin
      reduced = acc[DATA_WIDTH-1:0] - modulant;
    end else begin
      reduced = acc[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/from_montgomery.sv
// Converts a Montgomery-domain value T into T*R^-1 mod N by DATA_WIDTH
// serial REDC halvings plus a final conditional subtraction.
// Optional macro FROM_MONT_RANGE_CHECK_EN adds an error output for bad operands.
module from_montgomery
  import mont_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   modulant,
  input  logic [2*DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    busy,
  output logic                    done
`ifdef FROM_MONT_RANGE_CHECK_EN
  ,
  output logic                    error
`endif
);

  localparam int ACC_W = acc_width(DATA_WIDTH);
  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  mont_state_e state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [ACC_W-1:0]      n_ext;
  logic [ACC_W-1:0]      sum;
  logic [DATA_WIDTH-1:0] reduced;

`ifdef FROM_MONT_RANGE_CHECK_EN
  logic error_q, error_d;
  logic pend_err_q, pend_err_d;
  logic bad_operands;
`endif

  mont_cond_sub #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cond_sub (
    .acc      (acc_q),
    .modulant (modulant),
    .reduced  (reduced)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    n_ext    = {{(ACC_W-DATA_WIDTH){1'b0}}, modulant};
    sum      = acc_q + (acc_q[0] ? n_ext : '0);
`ifdef FROM_MONT_RANGE_CHECK_EN
    error_d      = error_q;
    pend_err_d   = pend_err_q;
    bad_operands = !modulant[0] || (a >= {modulant, {DATA_WIDTH{1'b0}}});
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = {1'b0, a};
          cnt_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ITER;
`ifdef FROM_MONT_RANGE_CHECK_EN
          error_d    = 1'b0;
          pend_err_d = bad_operands;
          // Bad operands skip the iterations and report on the next edge.
          if (bad_operands) state_d = CORRECT;
`endif
        end
      end
      ITER: begin
        acc_d = sum >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) state_d = CORRECT;
      end
      CORRECT: begin
        result_d = reduced;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
`ifdef FROM_MONT_RANGE_CHECK_EN
        if (pend_err_q) begin
          result_d = '0;
          error_d  = 1'b1;
        end
        pend_err_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef FROM_MONT_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_q    <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      error_q    <= error_d;
      pend_err_q <= pend_err_d;
    end
  end

  assign error = error_q;
`endif

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_from_montgomery.sv
// Directed bench for from_montgomery (DATA_WIDTH=8): vector table plus
// hand-written sequences for reset abort, ignored start and back-to-back runs.
module tb_from_montgomery;

  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [DW-1:0] modulant;
  logic [2*DW-1:0] a;
  logic [DW-1:0] result;
  logic          busy;
  logic          done;
`ifdef FROM_MONT_RANGE_CHECK_EN
  logic          error;
`endif

  from_montgomery #(.DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .modulant (modulant),
    .a        (a),
    .result   (result),
    .busy     (busy),
    .done     (done)
`ifdef FROM_MONT_RANGE_CHECK_EN
    ,
    .error    (error)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2*DW-1:0] a;
    logic [DW-1:0]   n;
    logic [DW-1:0]   exp;
  } vec_t;

  vec_t          vecs[10];
  logic [DW-1:0] exp_q[$];
  int            n_vec;
  int            n_bad;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one start pulse and checks latency, busy width and the queued result.
  task automatic run_op(input logic [2*DW-1:0] av, input logic [DW-1:0] nv, input string tag);
    int lat;
    int bcyc;
    logic [DW-1:0] exp;
    @(negedge clk);
    a = av; modulant = nv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_cleared"}, int'(done), 0);
    bcyc = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcyc++;
    end
    check({tag, " latency"}, lat, 9);
    check({tag, " busy_cycles"}, bcyc, 9);
    exp = exp_q.pop_front();
    check({tag, " result"}, int'(result), int'(exp));
  endtask

  initial begin
    int lat;
    int lowcnt;
    bit seen;
    logic [DW-1:0] exp;

    n_vec = 0;
    n_bad = 0;
    vecs[0] = '{a: 16'd1280,  n: 8'd13,  exp: 8'd5};
    vecs[1] = '{a: 16'd1,     n: 8'd13,  exp: 8'd3};
    vecs[2] = '{a: 16'd3327,  n: 8'd13,  exp: 8'd10};
    vecs[3] = '{a: 16'd0,     n: 8'd13,  exp: 8'd0};
    vecs[4] = '{a: 16'd65,    n: 8'd13,  exp: 8'd0};
    vecs[5] = '{a: 16'd512,   n: 8'd13,  exp: 8'd2};
    vecs[6] = '{a: 16'd1,     n: 8'd251, exp: 8'd201};
    vecs[7] = '{a: 16'd65279, n: 8'd255, exp: 8'd254};
    vecs[8] = '{a: 16'd255,   n: 8'd1,   exp: 8'd0};
    vecs[9] = '{a: 16'd64255, n: 8'd251, exp: 8'd50};

    reset = 1'b1; start = 1'b0; a = '0; modulant = 8'd13;
    repeat (3) @(negedge clk);
    check("reset result", int'(result), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(vecs[i].exp);
      run_op(vecs[i].a, vecs[i].n, $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d idle_hold", i), int'(result), int'(vecs[i].exp));
      check($sformatf("vec%0d done_level", i), int'(done), 1);
    end

    // Reset after four iterations aborts immediately and no done follows.
    @(negedge clk);
    a = 16'd1280; modulant = 8'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort result", int'(result), 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("abort no_done", int'(seen), 0);

    // A start pulse while busy must not re-sample the operands.
    exp_q.push_back(8'd5);
    @(negedge clk);
    a = 16'd1280; modulant = 8'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin a = 16'd1; start = 1'b1; end
      else start = 1'b0;
    end
    start = 1'b0;
    check("busy_start latency", lat, 9);
    exp = exp_q.pop_front();
    check("busy_start result", int'(result), int'(exp));

    // Start held high: a=0 then an automatic relaunch with a=1280.
    exp_q.push_back(8'd0);
    exp_q.push_back(8'd5);
    @(negedge clk);
    a = 16'd0; modulant = 8'd13; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
    check("held first latency", lat, 10);
    exp = exp_q.pop_front();
    check("held first result", int'(result), int'(exp));
    a = 16'd1280;
    @(negedge clk);
    check("held relaunch done", int'(done), 0);
    check("held relaunch busy", int'(busy), 1);
    lowcnt = 1;
    while (lowcnt < 20) begin
      @(negedge clk);
      if (done) break;
      lowcnt++;
    end
    start = 1'b0;
    check("held done_low_cycles", lowcnt, 9);
    exp = exp_q.pop_front();
    check("held second result", int'(result), int'(exp));

`ifdef FROM_MONT_RANGE_CHECK_EN
    // Even modulus reports an error one edge after start.
    @(negedge clk);
    a = 16'd100; modulant = 8'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("range error", int'(error), 1);
    check("range done", int'(done), 1);
    check("range result", int'(result), 0);
    exp_q.push_back(8'd5);
    run_op(16'd1280, 8'd13, "range_recover");
    check("range error_cleared", int'(error), 0);
`endif

    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/from_montgomery.md
FROM_MONTGOMERY -- requirements
Module: from_montgomery

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of modulant and result (Montgomery R = 2^DATA_WIDTH).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port modulant  input  DATA_WIDTH  odd modulus N, held stable while busy.
REQ-006 SHALL have port a  input  2*DATA_WIDTH  Montgomery-domain value T, T < N*R, sampled at the start edge.
REQ-007 SHALL have port result  output  DATA_WIDTH  T*R^-1 mod N.
REQ-008 SHALL have port busy  output  1  high from the accepting edge until the edge that sets done.
REQ-009 SHALL have port done  output  1  level; high from completion until the next accepted start or reset.

Function
REQ-010 SHALL implement states IDLE, ITER, CORRECT; encoding 2 bits.
REQ-011 IDLE: start=1 at edge k SHALL load internal accumulator (2*DATA_WIDTH+1 bits) with a, clear bit counter, clear done, set busy, go to ITER.
REQ-012 IDLE with start=0 SHALL hold result and done unchanged.
REQ-013 ITER: each edge SHALL do acc = (acc + (acc[0] ? N : 0)) >> 1 with no overflow loss; counter increments.
REQ-014 ITER SHALL execute exactly DATA_WIDTH iterations (edges k+1..k+DATA_WIDTH), then go to CORRECT.
REQ-015 CORRECT: at edge k+DATA_WIDTH+1, result SHALL be acc-N if acc >= N else acc (low DATA_WIDTH bits), done=1, busy=0, state IDLE.
REQ-016 Total latency SHALL be DATA_WIDTH+1 edges from start-sampling edge to done high; fixed, data-independent.
REQ-017 start asserted while busy SHALL be ignored; operands are not re-sampled.
REQ-018 start held high continuously SHALL re-launch on each IDLE edge, i.e. back-to-back operations every DATA_WIDTH+2 edges.
REQ-019 start at the same edge done is high SHALL be accepted; done falls at that edge.
REQ-020 a=0 SHALL yield result 0; T >= N*R or even N is undefined (see REQ-024).

Reset
REQ-021 reset=1 SHALL asynchronously force state IDLE, result 0, done 0, busy 0, accumulator and counter 0.
REQ-022 reset during ITER/CORRECT SHALL abort the operation; no done pulse follows; first operation after deassertion requires a fresh start.

Configuration
REQ-023 Macro FROM_MONT_RANGE_CHECK_EN SHALL gate an extra output error (1 bit, reset 0).
REQ-024 With FROM_MONT_RANGE_CHECK_EN defined: at the start edge, even modulant or a >= N*2^DATA_WIDTH SHALL skip ITER, set error=1, done=1, result 0 on the next edge; error clears on the next accepted start.
REQ-025 Without the macro: no error port, no check, behaviour per REQ-011..REQ-020 for all inputs.

Structure
REQ-026 Package mont_pkg SHALL hold the state enum typedef and shared widths (acc width = 2*DATA_WIDTH+1), shared with R_square generation logic.
REQ-027 Final conditional subtraction SHALL be a sub-module mont_cond_sub (input acc, N; output reduced value); everything else in from_montgomery.

Verification (DATA_WIDTH=8, N=13, R=256)
REQ-028 a=1280 (5*R), start pulse -> done high 9 edges later, result=5, busy high 9 cycles.
REQ-029 a=1 -> result=3 (256^-1 mod 13); a=3327 (N*R-1) -> result=10 exercising the subtract path.
REQ-030 a=0 -> result=0; then start held high -> second launch on the edge after done, done drops for 9 edges.
REQ-031 reset pulse at iteration 4 -> outputs 0 immediately (asynchronous), no done afterwards without new start; start pulse during busy -> ignored, result from the original operands.
REQ-032 With FROM_MONT_RANGE_CHECK_EN: N=12 -> error=1, done=1, result=0 one edge after start; next valid start with N=13 clears error.
